// File: rtl/pll_reset_sequencer.sv
`timescale 1ns/1ps
// pll_reset_sequencer
//
// Brings a PLL out of reset, waits for its lock flag to be stable, then
// releases the four derived clock-domain resets one after another.
// Lock loss after stabilisation restarts the whole sequence. Lock
// timeouts and post-stabilisation lock losses are counted.
//
// Ports
//   CLK           free-running board oscillator (also the PLL reference)
//   RST_N         asynchronous active-low reset
//   pll_locked    PLL lock flag, asynchronous to CLK
//   force_relock  single-cycle software request to restart the PLL
//   pll_reset     active-high reset to the PLL
//   dom_rst_n     active-low resets for the four derived domains
//   ready         all domains released and lock stable
//   lock_loss_cnt saturating count of lock losses after stabilisation
//   timeout_cnt   saturating count of lock timeouts
//
// STAGE_GAP must be at least 1.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int STAGE_GAP           = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_reset,
    output logic [3:0] dom_rst_n,
    output logic       ready,
    output logic [7:0] lock_loss_cnt,
    output logic [7:0] timeout_cnt
);

    localparam int PW = $clog2(PLL_RST_CYCLES + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(3 * STAGE_GAP + 1);

    localparam logic [PW-1:0] PULSE_LAST   = PW'(PLL_RST_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP1         = GW'(STAGE_GAP);
    localparam logic [GW-1:0] GAP2         = GW'(2 * STAGE_GAP);
    localparam logic [GW-1:0] GAP3         = GW'(3 * STAGE_GAP);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
    } state_t;

    state_t        state, state_next;
    logic          lock_meta, lock_sync;
    logic [PW-1:0] pulse_cnt, pulse_next;
    logic [SW-1:0] stable_cnt, stable_next;
    logic [TW-1:0] wait_cnt, wait_next;
    logic [GW-1:0] gap_cnt, gap_next;
    logic          pll_reset_next;
    logic [3:0]    dom_next;
    logic          ready_next;
    logic [7:0]    loss_next, timeouts_next;
    logic          restart, release_start, lost;

    // All outputs are flops; the combinational block computes their next
    // values together with the state so every output changes on the same
    // edge as the state transition that causes it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= PLL_RST;
            lock_meta     <= 1'b0;
            lock_sync     <= 1'b0;
            pulse_cnt     <= '0;
            stable_cnt    <= '0;
            wait_cnt      <= '0;
            gap_cnt       <= '0;
            pll_reset     <= 1'b1;
            dom_rst_n     <= 4'b0000;
            ready         <= 1'b0;
            lock_loss_cnt <= 8'd0;
            timeout_cnt   <= 8'd0;
        end else begin
            state         <= state_next;
            lock_meta     <= pll_locked;
            lock_sync     <= lock_meta;
            pulse_cnt     <= pulse_next;
            stable_cnt    <= stable_next;
            wait_cnt      <= wait_next;
            gap_cnt       <= gap_next;
            pll_reset     <= pll_reset_next;
            dom_rst_n     <= dom_next;
            ready         <= ready_next;
            lock_loss_cnt <= loss_next;
            timeout_cnt   <= timeouts_next;
        end
    end

    always_comb begin
        state_next     = state;
        pulse_next     = pulse_cnt;
        stable_next    = stable_cnt;
        wait_next      = wait_cnt;
        gap_next       = gap_cnt;
        pll_reset_next = pll_reset;
        dom_next       = dom_rst_n;
        ready_next     = ready;
        loss_next      = lock_loss_cnt;
        timeouts_next  = timeout_cnt;
        restart        = 1'b0;
        release_start  = 1'b0;
        lost           = 1'b0;

        case (state)
            // force_relock is deliberately not looked at here so a request
            // cannot stretch or restart a pulse already in progress.
            PLL_RST: begin
                if (pulse_cnt == PULSE_LAST) begin
                    state_next     = WAIT_LOCK;
                    pll_reset_next = 1'b0;
                    wait_next      = '0;
                end else begin
                    pulse_next = pulse_cnt + 1'b1;
                end
            end

            // A timeout coinciding with force_relock still counts once.
            WAIT_LOCK: begin
                if (!lock_sync && wait_cnt == TIMEOUT_LAST) begin
                    restart = 1'b1;
                    if (timeout_cnt != 8'hFF)
                        timeouts_next = timeout_cnt + 8'd1;
                end else if (force_relock) begin
                    restart = 1'b1;
                end else if (lock_sync) begin
                    stable_next = SW'(1);
                    if (LOCK_STABLE_CYCLES <= 1)
                        release_start = 1'b1;
                    else
                        state_next = STABLE;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end

            // A dropout here is a glitch before stabilisation, not a loss.
            STABLE: begin
                if (force_relock) begin
                    restart = 1'b1;
                end else if (!lock_sync) begin
                    state_next = WAIT_LOCK;
                    wait_next  = '0;
                end else begin
                    stable_next = stable_cnt + 1'b1;
                    if (stable_cnt == STABLE_LAST)
                        release_start = 1'b1;
                end
            end

            // gap_cnt counts cycles since dom_rst_n[0] rose; bits already
            // released are held because dom_next defaults to the current value.
            RELEASE: begin
                if (!lock_sync) begin
                    lost    = 1'b1;
                    restart = 1'b1;
                end else if (force_relock) begin
                    restart = 1'b1;
                end else begin
                    gap_next = gap_cnt + 1'b1;
                    if (gap_next >= GAP1) dom_next[1] = 1'b1;
                    if (gap_next >= GAP2) dom_next[2] = 1'b1;
                    if (gap_next == GAP3) begin
                        dom_next[3] = 1'b1;
                        ready_next  = 1'b1;
                        state_next  = RUN;
                    end
                end
            end

            RUN: begin
                if (!lock_sync) begin
                    lost    = 1'b1;
                    restart = 1'b1;
                end else if (force_relock) begin
                    restart = 1'b1;
                end
            end

            default: restart = 1'b1;
        endcase

        if (release_start) begin
            state_next = RELEASE;
            gap_next   = '0;
            dom_next   = 4'b0001;
        end

        if (lost && lock_loss_cnt != 8'hFF)
            loss_next = lock_loss_cnt + 8'd1;

        if (restart) begin
            state_next     = PLL_RST;
            pulse_next     = '0;
            pll_reset_next = 1'b1;
            dom_next       = 4'b0000;
            ready_next     = 1'b0;
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
`timescale 1ns/1ps
// Testbench for pll_reset_sequencer with small parameters. Expected
// outputs come from arithmetic on event times: the edge at which
// pll_locked is first sampled, the synchroniser depth, the stable
// window, the stage gap and the pulse/timeout lengths.
module tb_pll_reset_sequencer;

    localparam int PRC  = 4;
    localparam int LSC  = 8;
    localparam int LTC  = 32;
    localparam int GAP  = 2;
    localparam int SYNC = 2;

    logic       CLK;
    logic       RST_N;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_reset;
    logic [3:0] dom_rst_n;
    logic       ready;
    logic [7:0] lock_loss_cnt;
    logic [7:0] timeout_cnt;

    int cyc;
    int passed;
    int total;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (PRC),
        .LOCK_STABLE_CYCLES (LSC),
        .LOCK_TIMEOUT_CYCLES(LTC),
        .STAGE_GAP          (GAP)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .pll_locked   (pll_locked),
        .force_relock (force_relock),
        .pll_reset    (pll_reset),
        .dom_rst_n    (dom_rst_n),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] simulation timed out");
    end

    // Edge at which the domain release starts, given the first edge at
    // which pll_locked is sampled high and held. The FSM cannot look at
    // lock before its first WAIT_LOCK cycle (edge PRC+1).
    function automatic int release_edge(input int rise);
        int first;
        first = rise + SYNC;
        if (first < PRC + 1) first = PRC + 1;
        return first + LSC - 1;
    endfunction

    // {pll_reset, dom_rst_n, ready} after edge e of an undisturbed bring-up.
    function automatic logic [5:0] expect_bringup(input int e, input int rel);
        logic [3:0] d;
        d = 4'b0000;
        for (int b = 0; b < 4; b++)
            if (e >= rel + b * GAP) d[b] = 1'b1;
        return {(e < PRC), d, (e >= rel + 3 * GAP)};
    endfunction

    task automatic step;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic step_until(input int e);
        while (cyc < e) step;
    endtask

    task automatic apply_reset;
        RST_N        = 1'b0;
        pll_locked   = 1'b0;
        force_relock = 1'b0;
        step;
        step;
        RST_N = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset;
        logic [21:0] obs;
        logic [21:0] exp;
        RST_N = 1'b1;
        pll_locked = 1'b0;
        force_relock = 1'b0;
        #1;
        RST_N = 1'b0;
        #1;
        obs = {pll_reset, dom_rst_n, ready, lock_loss_cnt, timeout_cnt};
        exp = {1'b1, 4'b0000, 1'b0, 8'd0, 8'd0};
        total++;
        if (obs !== exp) $display("[TB] FAIL reset_values got %h expected %h", obs, exp);
        else passed++;
        step;
        step;
        RST_N = 1'b1;
        cyc = 0;
        for (int c = 1; c <= PRC + 2; c++) begin
            step;
            total++;
            if ({pll_reset, dom_rst_n, ready} !== {(c < PRC), 4'b0000, 1'b0})
                $display("[TB] FAIL first_pulse cycle %0d got %b%b%b", c, pll_reset, dom_rst_n, ready);
            else passed++;
        end
    endtask

    task automatic test_bringup;
        int d;
        int rel;
        logic [5:0] exp;
        for (int it = 0; it < 3; it++) begin
            apply_reset;
            d = $urandom_range(0, 25);
            rel = release_edge(d + 1);
            for (int e = 1; e <= rel + 3 * GAP + 3; e++) begin
                if (cyc == d) pll_locked = 1'b1;
                step;
                exp = expect_bringup(cyc, rel);
                total++;
                if ({pll_reset, dom_rst_n, ready} !== exp)
                    $display("[TB] FAIL bringup d=%0d cycle %0d got %b%b%b expected %b",
                             d, cyc, pll_reset, dom_rst_n, ready, exp);
                else passed++;
            end
        end
    endtask

    task automatic test_timeout;
        int period;
        logic [8:0] exp;
        period = PRC + LTC;
        apply_reset;
        for (int c = 1; c <= 3 * period + 6; c++) begin
            step;
            exp = {((c % period) < PRC), 8'(c / period)};
            total++;
            if ({pll_reset, timeout_cnt} !== exp)
                $display("[TB] FAIL timeout cycle %0d got %b/%0d expected %b/%0d",
                         c, pll_reset, timeout_cnt, exp[8], exp[7:0]);
            else passed++;
        end
    endtask

    task automatic test_glitch;
        int h;
        int low;
        int rel;
        logic [5:0] exp;
        apply_reset;
        step_until(6);
        h = $urandom_range(1, LSC - 1);
        low = $urandom_range(1, 3);
        pll_locked = 1'b1;
        for (int i = 0; i < h + low; i++) begin
            if (i == h) pll_locked = 1'b0;
            step;
            total++;
            if ({dom_rst_n, lock_loss_cnt} !== 12'd0)
                $display("[TB] FAIL glitch_hold cycle %0d got dom %b loss %0d", cyc, dom_rst_n, lock_loss_cnt);
            else passed++;
        end
        pll_locked = 1'b1;
        rel = release_edge(cyc + 1);
        while (cyc < rel + 3 * GAP + 1) begin
            step;
            exp = expect_bringup(cyc, rel);
            total++;
            if ({pll_reset, dom_rst_n, ready, lock_loss_cnt} !== {exp, 8'd0})
                $display("[TB] FAIL glitch_release h=%0d low=%0d cycle %0d got %b%b%b/%0d expected %b/0",
                         h, low, cyc, pll_reset, dom_rst_n, ready, lock_loss_cnt, exp);
            else passed++;
        end
    endtask

    task automatic test_loss;
        int rel;
        int k;
        logic [13:0] exp;
        for (int it = 0; it < 4; it++) begin
            apply_reset;
            pll_locked = 1'b1;
            rel = release_edge(1);
            k = rel - 1 + $urandom_range(0, 10);
            while (cyc < k + 7) begin
                if (cyc == k - 1) pll_locked = 1'b0;
                step;
                if (cyc < k + 2) exp = {expect_bringup(cyc, rel), 8'd0};
                else exp = {(cyc < k + 2 + PRC), 4'b0000, 1'b0, 8'd1};
                total++;
                if ({pll_reset, dom_rst_n, ready, lock_loss_cnt} !== exp)
                    $display("[TB] FAIL lock_loss k=%0d cycle %0d got %b%b%b/%0d expected %b",
                             k, cyc, pll_reset, dom_rst_n, ready, lock_loss_cnt, exp);
                else passed++;
            end
        end
    endtask

    task automatic test_force;
        int rel;
        int f;
        int g;
        logic [21:0] exp;
        for (int it = 0; it < 4; it++) begin
            apply_reset;
            pll_locked = 1'b1;
            rel = release_edge(1);
            f = $urandom_range(PRC + 1, rel + 3 * GAP + 3);
            g = $urandom_range(1, PRC - 1);
            while (cyc < f + PRC + 2) begin
                force_relock = (cyc == f - 1) || (cyc == f + g - 1);
                step;
                if (cyc < f) exp = {expect_bringup(cyc, rel), 16'd0};
                else exp = {(cyc < f + PRC), 4'b0000, 1'b0, 16'd0};
                total++;
                if ({pll_reset, dom_rst_n, ready, lock_loss_cnt, timeout_cnt} !== exp)
                    $display("[TB] FAIL force f=%0d g=%0d cycle %0d got %b%b%b/%0d/%0d expected %h",
                             f, g, cyc, pll_reset, dom_rst_n, ready, lock_loss_cnt, timeout_cnt, exp);
                else passed++;
            end
            force_relock = 1'b0;
        end
    endtask

    task automatic test_simultaneous;
        int k;
        apply_reset;
        pll_locked = 1'b1;
        k = release_edge(1) + 3 * GAP + 2;
        while (cyc < k + 2) begin
            pll_locked = (cyc < k - 1);
            force_relock = (cyc == k + 1);
            step;
        end
        force_relock = 1'b0;
        total++;
        if ({pll_reset, dom_rst_n, ready, lock_loss_cnt} !== {1'b1, 4'b0000, 1'b0, 8'd1})
            $display("[TB] FAIL loss_and_force got %b%b%b/%0d expected 100000/1",
                     pll_reset, dom_rst_n, ready, lock_loss_cnt);
        else passed++;
        step_until(k + 10);
        total++;
        if (lock_loss_cnt !== 8'd1)
            $display("[TB] FAIL loss_and_force_hold got %0d expected 1", lock_loss_cnt);
        else passed++;

        apply_reset;
        while (cyc < PRC + LTC) begin
            force_relock = (cyc == PRC + LTC - 1);
            step;
        end
        force_relock = 1'b0;
        total++;
        if ({pll_reset, timeout_cnt} !== {1'b1, 8'd1})
            $display("[TB] FAIL timeout_and_force got %b/%0d expected 1/1", pll_reset, timeout_cnt);
        else passed++;
        step_until(2 * PRC + LTC - 1);
        total++;
        if (pll_reset !== 1'b1)
            $display("[TB] FAIL timeout_and_force_pulse cycle %0d got %b expected 1", cyc, pll_reset);
        else passed++;
        step;
        total++;
        if ({pll_reset, timeout_cnt} !== {1'b0, 8'd1})
            $display("[TB] FAIL timeout_and_force_end got %b/%0d expected 0/1", pll_reset, timeout_cnt);
        else passed++;
    endtask

    task automatic test_saturation;
        int n;
        int exp_loss;
        apply_reset;
        pll_locked = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            n = 0;
            while (dom_rst_n[0] !== 1'b1 && n < 40) begin
                step;
                n++;
            end
            if (dom_rst_n[0] !== 1'b1) begin
                total++;
                $display("[TB] FAIL saturation_wait loss %0d got dom %b expected release", i, dom_rst_n);
                break;
            end
            pll_locked = 1'b0;
            step;
            step;
            step;
            exp_loss = (i > 255) ? 255 : i;
            total++;
            if (lock_loss_cnt !== 8'(exp_loss))
                $display("[TB] FAIL saturation loss %0d got %0d expected %0d", i, lock_loss_cnt, exp_loss);
            else passed++;
            pll_locked = 1'b1;
        end
    endtask

    task automatic test_async_reset;
        int n;
        logic [21:0] obs;
        apply_reset;
        step_until(PRC + LTC);
        total++;
        if (timeout_cnt !== 8'd1)
            $display("[TB] FAIL async_pre_timeout got %0d expected 1", timeout_cnt);
        else passed++;
        pll_locked = 1'b1;
        n = 0;
        while (dom_rst_n[0] !== 1'b1 && n < 40) begin
            step;
            n++;
        end
        step;
        total++;
        if (dom_rst_n !== 4'b0001)
            $display("[TB] FAIL async_mid_release got %b expected 0001", dom_rst_n);
        else passed++;
        #3;
        RST_N = 1'b0;
        #1;
        obs = {pll_reset, dom_rst_n, ready, lock_loss_cnt, timeout_cnt};
        total++;
        if (obs !== {1'b1, 4'b0000, 1'b0, 8'd0, 8'd0})
            $display("[TB] FAIL async_reset got %h expected %h", obs, {1'b1, 21'd0});
        else passed++;
        pll_locked = 1'b0;
        step;
        RST_N = 1'b1;
        cyc = 0;
        for (int c = 1; c <= PRC + 2; c++) begin
            step;
            total++;
            if (pll_reset !== (c < PRC))
                $display("[TB] FAIL post_reset_pulse cycle %0d got %b", c, pll_reset);
            else passed++;
        end
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        cyc          = 0;
        RST_N        = 1'b1;
        pll_locked   = 1'b0;
        force_relock = 1'b0;
        test_reset;
        test_bringup;
        test_timeout;
        test_glitch;
        test_loss;
        test_force;
        test_simultaneous;
        test_saturation;
        test_async_reset;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
